// File: rtl/rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// rf_write_arbiter
//
// Purpose
//   Shares the register file's single write port between the pipeline
//   writeback stage (WB) and the multi-cycle MUL/DIV unit (MDU).
//   - A one-entry buffer holds the most recent MDU result until it wins the
//     write port.
//   - WB normally has priority. An age counter counts the cycles a buffered
//     MDU result has lost arbitration. Once the counter reaches MAX_WAIT, the
//     MDU is granted even if WB is presenting a write.
//   - A busy scoreboard marks destinations that have an MDU op in flight.
//     Decode is stalled on any RAW or WAW hazard against those registers.
//
// Parameters
//   DATA_W    register data width
//   MAX_WAIT  number of lost arbitrations before a buffered result is forced
//             through (must be >= 1)
//
// Ports
//   CLOCK, RESET               clock; synchronous active-high reset
//   WB_VALID/WB_RD/WB_DATA     writeback write request
//   WB_STALL                   writeback write not taken this cycle
//   MDU_ISSUE/MDU_ISSUE_RD     MDU op issued; marks its destination busy
//   MDU_VALID/MDU_RD/MDU_DATA  MDU result offered to the buffer
//   MDU_READY                  buffer accepts a result this cycle
//   DEC_VALID/DEC_RS1/RS2/RD   decode-stage operands for hazard checking
//   DEC_STALL                  decode must hold
//   RF_WRITE/RF_ADDR/RF_DATA   register file write port
// ---------------------------------------------------------------------------
module rf_write_arbiter #(
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 4
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              WB_VALID,
  input  logic [4:0]        WB_RD,
  input  logic [DATA_W-1:0] WB_DATA,
  output logic              WB_STALL,
  input  logic              MDU_ISSUE,
  input  logic [4:0]        MDU_ISSUE_RD,
  input  logic              MDU_VALID,
  input  logic [4:0]        MDU_RD,
  input  logic [DATA_W-1:0] MDU_DATA,
  output logic              MDU_READY,
  input  logic              DEC_VALID,
  input  logic [4:0]        DEC_RS1,
  input  logic [4:0]        DEC_RS2,
  input  logic [4:0]        DEC_RD,
  output logic              DEC_STALL,
  output logic              RF_WRITE,
  output logic [4:0]        RF_ADDR,
  output logic [DATA_W-1:0] RF_DATA
);

  localparam int              AGE_W   = $clog2(MAX_WAIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(MAX_WAIT);

  // Saturating increment of the starvation age.
  function automatic logic [AGE_W-1:0] age_sat_inc(input logic [AGE_W-1:0] a);
    return (a == AGE_MAX) ? a : a + 1'b1;
  endfunction

  // State
  logic [31:0]       r_busy;
  logic              r_buf_valid;
  logic [4:0]        r_buf_rd;
  logic [DATA_W-1:0] r_buf_data;
  logic [AGE_W-1:0]  r_age;

  // Combinational decisions
  logic              w_grant_mdu;
  logic              w_grant_wb;
  logic              w_mdu_ready;
  logic              w_capture;
  logic              w_hazard;
  logic [31:0]       w_busy_nxt;
  logic [AGE_W-1:0]  w_age_nxt;
  logic              w_buf_valid_nxt;

  // Arbitration. All grants are qualified by !RESET so that every output
  // is quiet during reset, and no state update can slip past the reset.
  always_comb begin
    w_grant_mdu = !RESET && r_buf_valid && (!WB_VALID || (r_age == AGE_MAX));
    w_grant_wb  = !RESET && WB_VALID && !w_grant_mdu;
    // The buffer can be refilled in the same cycle it drains.
    // This allows back-to-back MDU results.
    w_mdu_ready = !RESET && (!r_buf_valid || w_grant_mdu);
    w_capture   = MDU_VALID && w_mdu_ready;
  end

  // Write port. A grant to x0 consumes the request without writing.
  always_comb begin
    RF_WRITE = (w_grant_mdu && (r_buf_rd != 5'd0)) ||
               (w_grant_wb  && (WB_RD    != 5'd0));
    RF_ADDR  = w_grant_mdu ? r_buf_rd   : WB_RD;
    RF_DATA  = w_grant_mdu ? r_buf_data : WB_DATA;
    WB_STALL = w_grant_mdu && WB_VALID;
    MDU_READY = w_mdu_ready;
  end

  // Hazard check. Bit 0 of the scoreboard is never set, so x0 cannot stall.
  always_comb begin
    w_hazard  = r_busy[DEC_RS1] | r_busy[DEC_RS2] | r_busy[DEC_RD];
    DEC_STALL = !RESET && DEC_VALID && w_hazard;
  end

  // Scoreboard next state. The set is applied after the clear, so that a
  // new issue to the same register wins over the retiring write.
  always_comb begin
    w_busy_nxt = r_busy;
    if (w_grant_mdu) begin
      w_busy_nxt[r_buf_rd] = 1'b0;
    end
    if (MDU_ISSUE) begin
      w_busy_nxt[MDU_ISSUE_RD] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Buffer occupancy and age next state. A capture only happens when the
  // buffer is empty or draining, so a captured result always starts at age 0.
  always_comb begin
    w_buf_valid_nxt = r_buf_valid;
    w_age_nxt       = r_age;
    if (w_grant_mdu) begin
      w_buf_valid_nxt = 1'b0;
      w_age_nxt       = '0;
    end else if (w_grant_wb && r_buf_valid) begin
      w_age_nxt       = age_sat_inc(r_age);
    end
    if (w_capture) begin
      w_buf_valid_nxt = 1'b1;
      w_age_nxt       = '0;
    end
  end

  // Control state: reset discards any buffered result and clears all busy bits.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      r_busy      <= '0;
      r_buf_valid <= 1'b0;
      r_age       <= '0;
    end else begin
      r_busy      <= w_busy_nxt;
      r_buf_valid <= w_buf_valid_nxt;
      r_age       <= w_age_nxt;
    end
  end

  // Buffer payload is only meaningful while r_buf_valid is set. For this
  // reason, it is not reset.
  always_ff @(posedge CLOCK) begin
    if (w_capture) begin
      r_buf_rd   <= MDU_RD;
      r_buf_data <= MDU_DATA;
    end
  end

endmodule

// File: tb/tb_rf_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_rf_write_arbiter
//
// Purpose
//   Testbench for rf_write_arbiter.
//   - Each table row drives one cycle of inputs and lists the outputs expected
//     in that cycle.
//   - Expected register-file writes are queued as rows are driven, and popped
//     whenever the DUT asserts RF_WRITE.
//   - A hand-written sequence afterwards exercises the whole scoreboard
//     across a reset.
// ---------------------------------------------------------------------------
module tb_rf_write_arbiter;

  localparam int DATA_W   = 32;
  localparam int MAX_WAIT = 4;

  logic              CLOCK = 1'b0;
  logic              RESET;
  logic              WB_VALID;
  logic [4:0]        WB_RD;
  logic [DATA_W-1:0] WB_DATA;
  logic              WB_STALL;
  logic              MDU_ISSUE;
  logic [4:0]        MDU_ISSUE_RD;
  logic              MDU_VALID;
  logic [4:0]        MDU_RD;
  logic [DATA_W-1:0] MDU_DATA;
  logic              MDU_READY;
  logic              DEC_VALID;
  logic [4:0]        DEC_RS1;
  logic [4:0]        DEC_RS2;
  logic [4:0]        DEC_RD;
  logic              DEC_STALL;
  logic              RF_WRITE;
  logic [4:0]        RF_ADDR;
  logic [DATA_W-1:0] RF_DATA;

  always #5 CLOCK = ~CLOCK;

  rf_write_arbiter #(.DATA_W(DATA_W), .MAX_WAIT(MAX_WAIT)) dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .WB_VALID(WB_VALID), .WB_RD(WB_RD), .WB_DATA(WB_DATA), .WB_STALL(WB_STALL),
    .MDU_ISSUE(MDU_ISSUE), .MDU_ISSUE_RD(MDU_ISSUE_RD),
    .MDU_VALID(MDU_VALID), .MDU_RD(MDU_RD), .MDU_DATA(MDU_DATA), .MDU_READY(MDU_READY),
    .DEC_VALID(DEC_VALID), .DEC_RS1(DEC_RS1), .DEC_RS2(DEC_RS2), .DEC_RD(DEC_RD),
    .DEC_STALL(DEC_STALL),
    .RF_WRITE(RF_WRITE), .RF_ADDR(RF_ADDR), .RF_DATA(RF_DATA)
  );

  typedef struct {
    logic        rst;
    logic        wbv;
    logic [4:0]  wbrd;
    logic [31:0] wbd;
    logic        iss;
    logic [4:0]  issrd;
    logic        mv;
    logic [4:0]  mrd;
    logic [31:0] md;
    logic        dv;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  drd;
    logic        rfw;
    logic [4:0]  rfa;
    logic [31:0] rfd;
    logic        wbs;
    logic        mrdy;
    logic        dst;
  } vec_t;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  vec_t tv[$];
  wr_t  sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic row(input vec_t r);
    tv.push_back(r);
  endtask

  task automatic idle_inputs();
    RESET = 1'b0; WB_VALID = 1'b0; WB_RD = '0; WB_DATA = '0;
    MDU_ISSUE = 1'b0; MDU_ISSUE_RD = '0;
    MDU_VALID = 1'b0; MDU_RD = '0; MDU_DATA = '0;
    DEC_VALID = 1'b0; DEC_RS1 = '0; DEC_RS2 = '0; DEC_RD = '0;
  endtask

  task automatic apply(input vec_t r);
    RESET = r.rst; WB_VALID = r.wbv; WB_RD = r.wbrd; WB_DATA = r.wbd;
    MDU_ISSUE = r.iss; MDU_ISSUE_RD = r.issrd;
    MDU_VALID = r.mv; MDU_RD = r.mrd; MDU_DATA = r.md;
    DEC_VALID = r.dv; DEC_RS1 = r.rs1; DEC_RS2 = r.rs2; DEC_RD = r.drd;
  endtask

  task automatic sample(input vec_t r, input int i);
    string tag;
    wr_t   e;
    tag = $sformatf("row%0d", i);
    chk({tag, ".RF_WRITE"},  RF_WRITE,  r.rfw);
    chk({tag, ".WB_STALL"},  WB_STALL,  r.wbs);
    chk({tag, ".MDU_READY"}, MDU_READY, r.mrdy);
    chk({tag, ".DEC_STALL"}, DEC_STALL, r.dst);
    if (RF_WRITE === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL %s.unexpected_write: got addr %0d data 0x%0h, expected no write",
                 tag, RF_ADDR, RF_DATA);
      end else begin
        e = sb.pop_front();
        chk({tag, ".RF_ADDR"}, RF_ADDR, e.a);
        chk({tag, ".RF_DATA"}, RF_DATA, e.d);
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1);
  end

  initial begin
    idle_inputs();

    // Reset with traffic on every input: nothing may leak through.
    row('{default:0, rst:1, wbv:1, wbrd:2, wbd:'h111, iss:1, issrd:8, mv:1, mrd:6, md:'h66, dv:1, rs1:8});
    row('{default:0, rst:1, wbv:1, wbrd:2, wbd:'h111, iss:1, issrd:8, mv:1, mrd:6, md:'h66, dv:1, rs1:8});
    row('{default:0, dv:1, rs1:8, rs2:6, drd:2, mrdy:1});
    // RAW against a pending MDU destination.
    row('{default:0, iss:1, issrd:5, mrdy:1});
    row('{default:0, dv:1, rs1:5, mrdy:1, dst:1});
    row('{default:0, dv:1, rs1:5, mv:1, mrd:5, md:'h19, mrdy:1, dst:1});
    row('{default:0, dv:1, rs1:5, rfw:1, rfa:5, rfd:'h19, mrdy:1, dst:1});
    row('{default:0, dv:1, rs1:5, mrdy:1});
    // Starvation: WB writes x2 continuously while x7 waits in the buffer.
    row('{default:0, wbv:1, wbrd:2, wbd:'h201, mv:1, mrd:7, md:'h77, rfw:1, rfa:2, rfd:'h201, mrdy:1});
    row('{default:0, wbv:1, wbrd:2, wbd:'h202, rfw:1, rfa:2, rfd:'h202});
    row('{default:0, wbv:1, wbrd:2, wbd:'h203, mv:1, mrd:12, md:'hCC, rfw:1, rfa:2, rfd:'h203});
    row('{default:0, wbv:1, wbrd:2, wbd:'h204, rfw:1, rfa:2, rfd:'h204});
    row('{default:0, wbv:1, wbrd:2, wbd:'h205, rfw:1, rfa:2, rfd:'h205});
    row('{default:0, wbv:1, wbrd:2, wbd:'h206, rfw:1, rfa:7, rfd:'h77, wbs:1, mrdy:1});
    row('{default:0, wbv:1, wbrd:2, wbd:'h206, rfw:1, rfa:2, rfd:'h206, mrdy:1});
    // Back-to-back MDU results.
    row('{default:0, mv:1, mrd:3, md:'hA, mrdy:1});
    row('{default:0, mv:1, mrd:4, md:'hB, rfw:1, rfa:3, rfd:'hA, mrdy:1});
    row('{default:0, rfw:1, rfa:4, rfd:'hB, mrdy:1});
    row('{default:0, mrdy:1});
    // Register x0 from every source.
    row('{default:0, wbv:1, wbrd:0, wbd:'h55, iss:1, issrd:0, mrdy:1});
    row('{default:0, dv:1, mv:1, mrd:0, md:'h99, mrdy:1});
    row('{default:0, dv:1, mrdy:1});
    row('{default:0, wbv:1, wbrd:1, wbd:'h11, rfw:1, rfa:1, rfd:'h11, mrdy:1});
    // Same-edge set and clear of x9: the set wins.
    row('{default:0, iss:1, issrd:9, mrdy:1});
    row('{default:0, mv:1, mrd:9, md:'h99, mrdy:1});
    row('{default:0, iss:1, issrd:9, dv:1, rs2:9, rfw:1, rfa:9, rfd:'h99, mrdy:1, dst:1});
    row('{default:0, dv:1, rs2:9, mrdy:1, dst:1});
    row('{default:0, mv:1, mrd:9, md:'h9A, dv:1, rs2:9, mrdy:1, dst:1});
    row('{default:0, dv:1, drd:9, rfw:1, rfa:9, rfd:'h9A, mrdy:1, dst:1});
    row('{default:0, dv:1, rs2:9, drd:9, mrdy:1});
    // Reset while a result is buffered: the result is discarded.
    row('{default:0, mv:1, mrd:10, md:'hAA, iss:1, issrd:10, mrdy:1});
    row('{default:0, rst:1, wbv:1, wbrd:3, wbd:'h33});
    row('{default:0, dv:1, drd:10, mrdy:1});

    for (int i = 0; i < tv.size(); i++) begin
      @(negedge CLOCK);
      apply(tv[i]);
      if (tv[i].rfw) sb.push_back('{a: tv[i].rfa, d: tv[i].rfd});
      #2;
      sample(tv[i], i);
    end
    chk("scoreboard_drained", 32'(sb.size()), 32'd0);

    // Mark every register busy, then verify a reset clears all of them.
    for (int r = 1; r < 32; r++) begin
      @(negedge CLOCK);
      idle_inputs();
      MDU_ISSUE = 1'b1;
      MDU_ISSUE_RD = 5'(r);
    end
    @(negedge CLOCK);
    idle_inputs();
    DEC_VALID = 1'b1;
    DEC_RS1 = 5'd17;
    #2;
    chk("all_busy.x17_stall", DEC_STALL, 1'b1);
    @(negedge CLOCK);
    RESET = 1'b1;
    #2;
    chk("all_busy.stall_forced_low_in_reset", DEC_STALL, 1'b0);
    for (int r = 1; r < 32; r++) begin
      @(negedge CLOCK);
      idle_inputs();
      DEC_VALID = 1'b1;
      DEC_RS1 = 5'(r);
      #2;
      chk($sformatf("post_reset.busy%0d", r), DEC_STALL, 1'b0);
    end

    @(negedge CLOCK);
    idle_inputs();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
